regs_file_mp: RTL and testbench
===============================

// Module: regs_file_mp
// PURPOSE
//  Parametrised multi-read-port integer register file for the pipelined RV32 core. Next generation of the
//  core's register file: NUM_READ async read ports, one sync write port, optional write->read bypass,
//  per-register busy scoreboard and a registered commit-trace port (replaces simulation prints). Sits
//  between decode (reads, busy check) and writeback (write, trace).
// PARAMETERS
//  DATA_WIDTH   32  register / write-data width
//  ADDR_WIDTH   32  PC width
//  NUM_REGS     32  architectural registers; power of 2, >=2; reg 0 hardwired to zero
//  NUM_READ      2  read ports, 1..4
//  BYPASS        1  1: read of the register being written this cycle returns reg_write_data
//  PC_DELAY      3  pipeline depth between pc input and the writeback of that instruction, >=1
//  PC_ADJ        4  constant subtracted from the delayed PC on trace_pc
//  (RNW = $clog2(NUM_REGS), derived)
// PORTS
//  clk               in   1                  clock; all state updates on posedge
//  reset             in   1                  synchronous, active-high
//  pc                in   ADDR_WIDTH         fetch PC, sampled every cycle
//  reg_write_enable  in   1                  1 => WRITE
//  reg_write_num     in   RNW                write index
//  reg_write_data    in   DATA_WIDTH         write data
//  reg_read_num      in   NUM_READ*RNW       read indices, port p at [p*RNW +: RNW]
//  reg_read_data     out  NUM_READ*DATA_WIDTH read data, port p at [p*DATA_WIDTH +: DATA_WIDTH]
//  reg_read_busy     out  NUM_READ           busy bit of each read port's register
//  sb_set_en         in   1                  mark sb_set_num busy (producer issued)
//  sb_set_num        in   RNW                register to mark
//  trace_valid       out  1                  one-cycle pulse per committed write
//  trace_pc          out  ADDR_WIDTH         PC of committed instruction
//  trace_rd          out  RNW                destination register
//  trace_data        out  DATA_WIDTH         value written
// BEHAVIOUR
//  Reset: while reset=1 at posedge, all regs, busy bits, pc_hist and trace outputs clear to 0.
//   Writes, sb sets and traces presented in the reset cycle are dropped. Reset mid-stream discards
//   every in-flight pc_hist entry; traces in the next PC_DELAY cycles carry trace_pc = 0 - PC_ADJ.
//  Write: at posedge, if reg_write_enable && reg_write_num!=0 && !reset: regs[num] <= data. Writes to reg 0 ignored.
//  Read: combinational. Index 0 -> 0. Else if BYPASS && reg_write_enable && num==reg_write_num -> reg_write_data;
//   else stored value. BYPASS=0: old value until the posedge.
//  Scoreboard busy[NUM_REGS]: accepted write clears busy[reg_write_num]; sb_set_en sets busy[sb_set_num].
//   Same register set and cleared in one cycle: set wins. busy[0] is constant 0; setting reg 0 is ignored.
//   reg_read_busy[p] = busy[reg_read_num[p]], registered state only (no same-cycle bypass of set/clear).
//  PC history: pc_hist[1] <= pc; pc_hist[k] <= pc_hist[k-1], k=2..PC_DELAY; all cleared on reset.
//  Trace: registered, latency 1. For each accepted write (num!=0) in cycle N, in cycle N+1:
//   trace_valid=1, trace_rd=num, trace_data=data, trace_pc = pc_hist[PC_DELAY] - PC_ADJ sampled in cycle N
//   (mod 2^ADDR_WIDTH wrap). Else trace_valid=0; other trace fields hold previous values.
//  Back-to-back writes produce back-to-back trace pulses; no buffering or stall needed.
//  Several read ports with the same index return identical data/busy.
// TESTING
//  1 reset held 2 cycles, then read every reg on all ports -> all data 0, all busy 0, trace_valid 0.
//  2 write x5=0xDEADBEEF; same cycle read x5 -> BYPASS=1: 0xDEADBEEF, BYPASS=0: 0; next cycle 0xDEADBEEF both.
//  3 write x0=0x1234 -> read x0 = 0, no trace pulse, busy[0] stays 0.
//  4 sb_set x7; read x7 busy=1; write x7 + sb_set x7 same cycle -> busy stays 1; write x7 alone -> busy 0.
//  5 pc ramp 0x100,0x104,.. each cycle, write x3 when pc_hist[3]=0x108 -> next cycle trace_valid=1,
//    trace_pc=0x104, trace_rd=3; write every cycle -> continuous trace pulses.
//  6 reset asserted mid-ramp with pending write -> write dropped, regs/busy 0, trace_pc=0xFFFFFFFC next write.

Source files
------------

// File: rtl/regs_file_mp.sv
// Multi-read-port integer register file with write bypass, busy scoreboard
// and a registered commit-trace port for the pipelined RV32 core.
module regs_file_mp #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned NUM_READ   = 2,
  parameter int unsigned BYPASS     = 1,
  parameter int unsigned PC_DELAY   = 3,
  parameter int unsigned PC_ADJ     = 4,
  localparam int unsigned RNW       = $clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ADDR_WIDTH-1:0]          pc,
  input  logic                           reg_write_enable,
  input  logic [RNW-1:0]                 reg_write_num,
  input  logic [DATA_WIDTH-1:0]          reg_write_data,
  input  logic [NUM_READ*RNW-1:0]        reg_read_num,
  output logic [NUM_READ*DATA_WIDTH-1:0] reg_read_data,
  output logic [NUM_READ-1:0]            reg_read_busy,
  input  logic                           sb_set_en,
  input  logic [RNW-1:0]                 sb_set_num,
  output logic                           trace_valid,
  output logic [ADDR_WIDTH-1:0]          trace_pc,
  output logic [RNW-1:0]                 trace_rd,
  output logic [DATA_WIDTH-1:0]          trace_data
);

  // PC history is a flat shift line; slot k (1..PC_DELAY) sits at [(k-1)*ADDR_WIDTH +: ADDR_WIDTH]
  localparam int unsigned HW = PC_DELAY * ADDR_WIDTH;

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]                 busy_q, busy_d;
  logic [HW-1:0]                       pc_hist_q, pc_hist_d;
  logic                                trace_valid_q, trace_valid_d;
  logic [ADDR_WIDTH-1:0]               trace_pc_q, trace_pc_d;
  logic [RNW-1:0]                      trace_rd_q, trace_rd_d;
  logic [DATA_WIDTH-1:0]               trace_data_q, trace_data_d;
  logic                                wr_acc_c;

  // A write is architecturally accepted only outside reset and never for x0
  always_comb begin
    wr_acc_c = reg_write_enable && (reg_write_num != '0) && !reset;
  end

  // Next-state: register write, scoreboard, PC history and trace capture
  always_comb begin
    regs_d        = regs_q;
    busy_d        = busy_q;
    pc_hist_d     = HW'({pc_hist_q, pc});
    trace_valid_d = 1'b0;
    trace_pc_d    = trace_pc_q;
    trace_rd_d    = trace_rd_q;
    trace_data_d  = trace_data_q;

    if (wr_acc_c) begin
      regs_d[reg_write_num] = reg_write_data;
      busy_d[reg_write_num] = 1'b0;
      trace_valid_d         = 1'b1;
      trace_rd_d            = reg_write_num;
      trace_data_d          = reg_write_data;
      trace_pc_d            = pc_hist_q[(PC_DELAY-1)*ADDR_WIDTH +: ADDR_WIDTH] - ADDR_WIDTH'(PC_ADJ);
    end

    // Set applied after clear so a same-cycle set wins
    if (sb_set_en && (sb_set_num != '0)) begin
      busy_d[sb_set_num] = 1'b1;
    end

    regs_d[0] = '0;
    busy_d[0] = 1'b0;

    if (reset) begin
      regs_d        = '0;
      busy_d        = '0;
      pc_hist_d     = '0;
      trace_valid_d = 1'b0;
      trace_pc_d    = '0;
      trace_rd_d    = '0;
      trace_data_d  = '0;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    regs_q        <= regs_d;
    busy_q        <= busy_d;
    pc_hist_q     <= pc_hist_d;
    trace_valid_q <= trace_valid_d;
    trace_pc_q    <= trace_pc_d;
    trace_rd_q    <= trace_rd_d;
    trace_data_q  <= trace_data_d;
  end

  // Combinational read ports with optional write-through bypass
  for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
    logic [RNW-1:0] idx_c;

    // Per-port data and busy lookup
    always_comb begin
      idx_c = reg_read_num[p*RNW +: RNW];
      reg_read_busy[p] = busy_q[idx_c];
      if (idx_c == '0) begin
        reg_read_data[p*DATA_WIDTH +: DATA_WIDTH] = '0;
      end else if ((BYPASS != 0) && reg_write_enable && (idx_c == reg_write_num)) begin
        reg_read_data[p*DATA_WIDTH +: DATA_WIDTH] = reg_write_data;
      end else begin
        reg_read_data[p*DATA_WIDTH +: DATA_WIDTH] = regs_q[idx_c];
      end
    end
  end

  assign trace_valid = trace_valid_q;
  assign trace_pc    = trace_pc_q;
  assign trace_rd    = trace_rd_q;
  assign trace_data  = trace_data_q;

endmodule

// File: tb/tb_regs_file_mp.sv
// Scoreboard bench for regs_file_mp (default parameters, BYPASS=1).
module tb_regs_file_mp;

  localparam int unsigned RNW = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        reg_write_enable;
  logic [4:0]  reg_write_num;
  logic [31:0] reg_write_data;
  logic [9:0]  reg_read_num;
  logic [63:0] reg_read_data;
  logic [1:0]  reg_read_busy;
  logic        sb_set_en;
  logic [4:0]  sb_set_num;
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [4:0]  trace_rd;
  logic [31:0] trace_data;

  regs_file_mp dut (
    .clk(clk), .reset(reset), .pc(pc),
    .reg_write_enable(reg_write_enable), .reg_write_num(reg_write_num),
    .reg_write_data(reg_write_data), .reg_read_num(reg_read_num),
    .reg_read_data(reg_read_data), .reg_read_busy(reg_read_busy),
    .sb_set_en(sb_set_en), .sb_set_num(sb_set_num),
    .trace_valid(trace_valid), .trace_pc(trace_pc),
    .trace_rd(trace_rd), .trace_data(trace_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          port;
    logic [31:0] data;
    logic        busy;
    string       nm;
  } rd_exp_t;

  typedef struct {
    int          cyc;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
  } tr_exp_t;

  rd_exp_t     rd_q[$];
  tr_exp_t     tr_q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          last_rst = -1;
  bit          mon_en = 1'b0;
  logic [31:0] pc_seen[int];

  task automatic step();
    pc_seen[cyc] = pc;
    if (reset) last_rst = cyc;
    @(posedge clk);
    #1;
    cyc++;
    pc = pc + 32'd4;
    reg_write_enable = 1'b0;
    sb_set_en = 1'b0;
  endtask

  task automatic drive_rd(input int r0, input int r1);
    reg_read_num = {RNW'(r1), RNW'(r0)};
  endtask

  task automatic wr(input int num, input logic [31:0] data);
    reg_write_enable = 1'b1;
    reg_write_num = RNW'(num);
    reg_write_data = data;
  endtask

  task automatic sb(input int num);
    sb_set_en = 1'b1;
    sb_set_num = RNW'(num);
  endtask

  task automatic exp_rd(input int p, input logic [31:0] d, input logic b, input string nm);
    rd_exp_t e;
    e.cyc = cyc; e.port = p; e.data = d; e.busy = b; e.nm = nm;
    rd_q.push_back(e);
  endtask

  task automatic exp_tr(input logic [31:0] tpc, input int rd, input logic [31:0] d);
    tr_exp_t e;
    e.cyc = cyc + 1; e.pc = tpc; e.rd = RNW'(rd); e.data = d;
    tr_q.push_back(e);
  endtask

  // Expected trace PC for a write in cycle n: PC from PC_DELAY cycles earlier, zero if a reset intervened
  function automatic logic [31:0] exp_pc(input int n);
    int m;
    m = n - 3;
    if (m <= last_rst || !pc_seen.exists(m)) return 32'hFFFF_FFFC;
    return pc_seen[m] - 32'd4;
  endfunction

  // Monitor: compares read ports and the trace port at each negedge
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        while (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
          rd_exp_t e;
          e = rd_q.pop_front();
          total++;
          if (e.cyc < cyc) begin
            bad++;
            $display("FAIL %s: check missed (cycle %0d, now %0d)", e.nm, e.cyc, cyc);
          end else if (reg_read_data[e.port*32 +: 32] !== e.data ||
                       reg_read_busy[e.port] !== e.busy) begin
            bad++;
            $display("FAIL %s: port%0d got data=%h busy=%b, want data=%h busy=%b",
                     e.nm, e.port, reg_read_data[e.port*32 +: 32], reg_read_busy[e.port],
                     e.data, e.busy);
          end
        end
        begin
          bit exp_v;
          exp_v = (tr_q.size() > 0) && (tr_q[0].cyc == cyc);
          total++;
          if (trace_valid !== exp_v) begin
            bad++;
            $display("FAIL trace_valid: cycle %0d got %b want %b", cyc, trace_valid, exp_v);
          end
          if (exp_v) begin
            tr_exp_t t;
            t = tr_q.pop_front();
            total++;
            if (trace_pc !== t.pc || trace_rd !== t.rd || trace_data !== t.data) begin
              bad++;
              $display("FAIL trace_fields: cycle %0d got pc=%h rd=%0d data=%h want pc=%h rd=%0d data=%h",
                       cyc, trace_pc, trace_rd, trace_data, t.pc, t.rd, t.data);
            end
          end
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; pc = 32'h100;
    reg_write_enable = 1'b0; reg_write_num = '0; reg_write_data = '0;
    reg_read_num = '0; sb_set_en = 1'b0; sb_set_num = '0;

    // Reset held two cycles
    step();
    mon_en = 1'b1;
    step();
    reset = 1'b0;

    // All registers read back zero and not busy on both ports
    for (int i = 0; i < 32; i++) begin
      drive_rd(i, i);
      exp_rd(0, 32'h0, 1'b0, "reset_p0");
      exp_rd(1, 32'h0, 1'b0, "reset_p1");
      step();
    end

    // Write x5 with same-cycle bypass, then stored value
    wr(5, 32'hDEAD_BEEF); drive_rd(5, 6);
    exp_rd(0, 32'hDEAD_BEEF, 1'b0, "bypass_x5");
    exp_rd(1, 32'h0, 1'b0, "bypass_other");
    exp_tr(exp_pc(cyc), 5, 32'hDEAD_BEEF);
    step();
    drive_rd(5, 5);
    exp_rd(0, 32'hDEAD_BEEF, 1'b0, "stored_x5_p0");
    exp_rd(1, 32'hDEAD_BEEF, 1'b0, "stored_x5_p1");
    step();

    // Write to x0 is ignored, no trace
    wr(0, 32'h1234); drive_rd(0, 5);
    exp_rd(0, 32'h0, 1'b0, "x0_bypass");
    step();
    drive_rd(0, 0);
    exp_rd(0, 32'h0, 1'b0, "x0_after");
    step();

    // Scoreboard set / clear, set wins on collision
    sb(7); drive_rd(7, 0);
    exp_rd(0, 32'h0, 1'b0, "sb_same_cycle");
    step();
    sb(7); wr(7, 32'h77); drive_rd(7, 7);
    exp_rd(0, 32'h77, 1'b1, "sb_busy");
    exp_rd(1, 32'h77, 1'b1, "sb_busy_p1");
    exp_tr(exp_pc(cyc), 7, 32'h77);
    step();
    wr(7, 32'h78); drive_rd(7, 0);
    exp_rd(0, 32'h78, 1'b1, "sb_set_wins");
    exp_tr(exp_pc(cyc), 7, 32'h78);
    step();
    sb(0); drive_rd(7, 0);
    exp_rd(0, 32'h78, 1'b0, "sb_cleared");
    step();
    drive_rd(0, 7);
    exp_rd(0, 32'h0, 1'b0, "sb_x0_ignored");
    exp_rd(1, 32'h78, 1'b0, "sb_x7_p1");
    step();

    // PC ramp from 0x100; writes every cycle starting when pc_hist[3]=0x108
    pc = 32'h100;
    for (int i = 0; i < 5; i++) step();
    for (int i = 0; i < 4; i++) begin
      wr(3, 32'h300 + 32'(i)); drive_rd(3, 3);
      exp_rd(0, 32'h300 + 32'(i), 1'b0, "ramp_bypass");
      exp_tr(32'h104 + 32'(4 * i), 3, 32'h300 + 32'(i));
      step();
    end

    // Reset mid-stream with pending write and sb set
    sb(11);
    step();
    reset = 1'b1; wr(9, 32'h99); sb(10);
    step();
    reset = 1'b0;
    drive_rd(9, 10);
    exp_rd(0, 32'h0, 1'b0, "rst_drop_x9");
    exp_rd(1, 32'h0, 1'b0, "rst_busy_x10");
    wr(4, 32'h44);
    exp_tr(32'hFFFF_FFFC, 4, 32'h44);
    step();
    drive_rd(3, 11);
    exp_rd(0, 32'h0, 1'b0, "rst_clear_x3");
    exp_rd(1, 32'h0, 1'b0, "rst_busy_x11");
    wr(4, 32'h45);
    exp_tr(32'hFFFF_FFFC, 4, 32'h45);
    step();
    wr(4, 32'h46);
    exp_tr(32'hFFFF_FFFC, 4, 32'h46);
    step();
    wr(4, 32'h47); drive_rd(4, 7);
    exp_rd(1, 32'h0, 1'b0, "rst_clear_x7");
    exp_tr(exp_pc(cyc), 4, 32'h47);
    step();
    drive_rd(4, 4);
    exp_rd(0, 32'h47, 1'b0, "post_rst_x4");
    step();
    step();

    while (rd_q.size() > 0) begin
      rd_exp_t e;
      e = rd_q.pop_front();
      total++; bad++;
      $display("FAIL %s: read check never performed", e.nm);
    end
    while (tr_q.size() > 0) begin
      tr_exp_t t;
      t = tr_q.pop_front();
      total++; bad++;
      $display("FAIL trace_missing: expected pulse at cycle %0d rd=%0d never seen", t.cyc, t.rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
